// File: rtl/gpio_write_arbiter_if.sv
// Requester/decoder bundle for gpio_write_arbiter: per-requester valid/ready write
// requests on one side, the timed address/data/data_ready decoder interface on the other.
interface gpio_write_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 14,
  parameter int unsigned BusWidth  = 32
);
  localparam int unsigned IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]           req_valid;
  logic [NumReq*AddrWidth-1:0] req_address;
  logic [NumReq*BusWidth-1:0]  req_data;
  logic [NumReq-1:0]           req_ready;
  logic [AddrWidth-1:0]        address;
  logic [BusWidth-1:0]         data_out;
  logic                        data_ready;
  logic                        busy;
  logic [IdWidth-1:0]          grant_id;
  logic                        addr_err;

  modport master (
    output req_valid, req_address, req_data,
    input  req_ready, address, data_out, data_ready, busy, grant_id, addr_err
  );

  modport slave (
    input  req_valid, req_address, req_data,
    output req_ready, address, data_out, data_ready, busy, grant_id, addr_err
  );
endinterface

// File: rtl/gpio_write_arbiter.sv
// Round-robin write arbiter in front of the GPIO DDR/output decoder: setup, held strobe,
// recovery gap. Optional write/error counters enabled by GPIO_WRITE_ARBITER_COUNT_EN.
module gpio_write_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned AddrWidth     = 14,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned HoldCycles    = 4,
  parameter int unsigned RecoverCycles = 6
) (
  input  logic                    CLOCK,
  input  logic                    reset_reg,
  gpio_write_arbiter_if.slave     bus
`ifdef GPIO_WRITE_ARBITER_COUNT_EN
  ,
  output logic [15:0]             write_count,
  output logic [7:0]              err_count
`endif
);

  localparam int unsigned IdWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntMax   = (HoldCycles > RecoverCycles) ? HoldCycles : RecoverCycles;
  localparam int unsigned CntWidth = $clog2(CntMax + 1);
  localparam logic [31:0] WinLo    = 32'h0000_1100;
  localparam logic [31:0] WinHi    = 32'h0000_1114;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRecover} state_e;

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [IdWidth-1:0]     ptr_q, ptr_d;
  logic [IdWidth-1:0]     grant_q, grant_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [BusWidth-1:0]    data_q, data_d;
  logic                   err_q, err_d;

  logic [IdWidth-1:0]     winner;
  logic                   win_found;
  logic                   accept;
  logic                   in_window;
  logic [AddrWidth-1:0]   win_addr;
  logic [BusWidth-1:0]    win_data;
  logic [31:0]            win_addr32;

  // First valid requester searching upward from the pointer, wrapping at NumReq.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        winner    = idx[IdWidth-1:0];
      end
    end
  end

  assign win_addr   = bus.req_address[int'(winner)*AddrWidth +: AddrWidth];
  assign win_data   = bus.req_data[int'(winner)*BusWidth +: BusWidth];
  assign win_addr32 = 32'(win_addr);
  assign in_window  = (win_addr32 >= WinLo) && (win_addr32 <= WinHi) && (win_addr[1:0] == 2'b00);

  // Reset gates the grant so nothing is accepted while reset_reg is high.
  assign accept = (state_q == StIdle) && win_found && !reset_reg;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = win_addr;
          data_d  = win_data;
          grant_d = winner;
          if (int'(winner) + 1 >= NumReq) ptr_d = '0;
          else                            ptr_d = winner + IdWidth'(1);
          if (in_window) state_d = StSetup;
          else           err_d   = 1'b1;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = CntWidth'(HoldCycles);
      end
      StStrobe: begin
        if (cnt_q == CntWidth'(1)) begin
          state_d = StRecover;
          cnt_d   = CntWidth'(RecoverCycles);
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StRecover: begin
        if (cnt_q == CntWidth'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (reset_reg) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.address    = addr_q;
  assign bus.data_out   = data_q;
  assign bus.data_ready = (state_q == StStrobe);
  assign bus.busy       = (state_q != StIdle);
  assign bus.grant_id   = grant_q;
  assign bus.addr_err   = err_q;

`ifdef GPIO_WRITE_ARBITER_COUNT_EN
  logic [15:0] write_count_q, write_count_d;
  logic [7:0]  err_count_q, err_count_d;

  always_comb begin
    write_count_d = write_count_q;
    err_count_d   = err_count_q;
    if (state_q == StStrobe && cnt_q == CntWidth'(1) && write_count_q != 16'hFFFF) begin
      write_count_d = write_count_q + 16'd1;
    end
    if (err_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset_reg) begin
      write_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      write_count_q <= write_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign write_count = write_count_q;
  assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Directed self-checking bench for gpio_write_arbiter with hand-computed expectations.
module tb_gpio_write_arbiter;
  localparam int unsigned NumReq    = 2;
  localparam int unsigned AddrWidth = 14;
  localparam int unsigned BusWidth  = 32;

  logic CLOCK = 1'b0;
  logic reset_reg;
  int   total = 0;
  int   bad   = 0;

  gpio_write_arbiter_if #(.NumReq(NumReq), .AddrWidth(AddrWidth), .BusWidth(BusWidth)) bus ();

`ifdef GPIO_WRITE_ARBITER_COUNT_EN
  logic [15:0] write_count;
  logic [7:0]  err_count;
`endif

  gpio_write_arbiter #(
    .NumReq(NumReq), .AddrWidth(AddrWidth), .BusWidth(BusWidth),
    .HoldCycles(4), .RecoverCycles(6)
  ) dut (
    .CLOCK(CLOCK),
    .reset_reg(reset_reg),
    .bus(bus)
`ifdef GPIO_WRITE_ARBITER_COUNT_EN
    ,
    .write_count(write_count),
    .err_count(err_count)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AddrWidth-1:0] a, input logic [BusWidth-1:0] d);
    bus.req_address[i*AddrWidth +: AddrWidth] = a;
    bus.req_data[i*BusWidth +: BusWidth]      = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    check_eq("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic run_write(input int i, input logic [AddrWidth-1:0] a, input logic [BusWidth-1:0] d);
    int n = 0;
    set_req(i, a, d);
    bus.req_valid[i] = 1'b1;
    #1;
    while (!bus.req_ready[i] && n < 40) begin
      step();
      n++;
    end
    check_eq("rw_ready", 64'(bus.req_ready[i]), 64'd1);
    step();
    bus.req_valid[i] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int exp_id;
    reset_reg       = 1'b1;
    bus.req_valid   = 2'b11;
    bus.req_address = '0;
    bus.req_data    = '0;
    set_req(0, 14'h1104, 32'h00FF00FF);
    set_req(1, 14'h1108, 32'h0000000B);
    step();
    step();
    check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_dr", 64'(bus.data_ready), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_addr", 64'(bus.address), 64'd0);
    check_eq("rst_data", 64'(bus.data_out), 64'd0);
    check_eq("rst_gid", 64'(bus.grant_id), 64'd0);
    check_eq("rst_err", 64'(bus.addr_err), 64'd0);

    // Single write: accept in this cycle (T0), pointer starts at requester 0.
    reset_reg = 1'b0;
    #1;
    check_eq("sw_ready", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 2'b00;
    check_eq("sw_addr", 64'(bus.address), 64'h1104);
    check_eq("sw_data", 64'(bus.data_out), 64'h00FF00FF);
    check_eq("sw_gid", 64'(bus.grant_id), 64'd0);
    check_eq("sw_setup_dr", 64'(bus.data_ready), 64'd0);
    check_eq("sw_setup_busy", 64'(bus.busy), 64'd1);
    for (int c = 2; c <= 12; c++) begin
      step();
      check_eq("sw_dr", 64'(bus.data_ready), (c <= 5) ? 64'd1 : 64'd0);
      check_eq("sw_busy", 64'(bus.busy), (c <= 11) ? 64'd1 : 64'd0);
      check_eq("sw_addr_hold", 64'(bus.address), 64'h1104);
    end

    // Contention: pointer now at 1, so grants run 1,0,1,0.
    set_req(0, 14'h1100, 32'h0000000A);
    set_req(1, 14'h1108, 32'h0000000B);
    bus.req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_id = (g % 2 == 0) ? 1 : 0;
      #1;
      check_eq("ct_ready", 64'(bus.req_ready), 64'(1 << exp_id));
      step();
      check_eq("ct_gid", 64'(bus.grant_id), 64'(exp_id));
      check_eq("ct_addr", 64'(bus.address), exp_id == 1 ? 64'h1108 : 64'h1100);
      check_eq("ct_data", 64'(bus.data_out), exp_id == 1 ? 64'hB : 64'hA);
      if (g == 3) bus.req_valid = 2'b00;
      repeat (11) step();
    end
    check_eq("ct_idle", 64'(bus.busy), 64'd0);

    // Invalid addresses: above the window, then misaligned; one-cycle turnaround.
    set_req(1, 14'h1118, 32'h0000000C);
    bus.req_valid = 2'b10;
    #1;
    check_eq("inv_ready0", 64'(bus.req_ready), 64'b10);
    step();
    check_eq("inv_err0", 64'(bus.addr_err), 64'd1);
    check_eq("inv_busy0", 64'(bus.busy), 64'd0);
    check_eq("inv_addr0", 64'(bus.address), 64'h1118);
    set_req(1, 14'h1101, 32'h0000000D);
    #1;
    check_eq("inv_ready1", 64'(bus.req_ready), 64'b10);
    step();
    check_eq("inv_err1", 64'(bus.addr_err), 64'd1);
    check_eq("inv_addr1", 64'(bus.address), 64'h1101);
    check_eq("inv_dr1", 64'(bus.data_ready), 64'd0);
    bus.req_valid = 2'b00;
    step();
    check_eq("inv_err_clr", 64'(bus.addr_err), 64'd0);
    check_eq("inv_dr2", 64'(bus.data_ready), 64'd0);

    // Mid-strobe reset with requester 1 pending.
    set_req(0, 14'h1110, 32'h00000055);
    set_req(1, 14'h1114, 32'h00000066);
    bus.req_valid = 2'b11;
    #1;
    check_eq("mr_ready", 64'(bus.req_ready), 64'b01);
    step();
    bus.req_valid = 2'b10;
    step();
    check_eq("mr_dr_t2", 64'(bus.data_ready), 64'd1);
    step();
    reset_reg = 1'b1;
    step();
    check_eq("mr_dr", 64'(bus.data_ready), 64'd0);
    check_eq("mr_busy", 64'(bus.busy), 64'd0);
    check_eq("mr_addr", 64'(bus.address), 64'd0);
    check_eq("mr_ready_rst", 64'(bus.req_ready), 64'd0);
    reset_reg = 1'b0;
    #1;
    check_eq("mr_ready_rel", 64'(bus.req_ready), 64'b10);
    step();
    bus.req_valid = 2'b00;
    check_eq("mr_gid", 64'(bus.grant_id), 64'd1);
    check_eq("mr_addr2", 64'(bus.address), 64'h1114);
    check_eq("mr_data2", 64'(bus.data_out), 64'h66);
    repeat (11) step();
    check_eq("mr_idle", 64'(bus.busy), 64'd0);

`ifdef GPIO_WRITE_ARBITER_COUNT_EN
    reset_reg = 1'b1;
    step();
    reset_reg = 1'b0;
    check_eq("cnt_rst_w", 64'(write_count), 64'd0);
    check_eq("cnt_rst_e", 64'(err_count), 64'd0);
    run_write(0, 14'h1100, 32'h1);
    run_write(1, 14'h1104, 32'h2);
    run_write(0, 14'h1118, 32'h3);
    run_write(1, 14'h1114, 32'h4);
    check_eq("cnt_w", 64'(write_count), 64'd3);
    check_eq("cnt_e", 64'(err_count), 64'd1);
    force dut.write_count_q = 16'hFFFF;
    step();
    release dut.write_count_q;
    run_write(0, 14'h110C, 32'h5);
    check_eq("cnt_sat", 64'(write_count), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
